aes_decrypt_iter: RTL and testbench

//  Iterative AES-128 decryption core; inverse counterpart of the encrypt-stage datapath.

---
 rtl/aes_decrypt_pkg.sv | 67 ++++++
 rtl/aes_inv_mix_column.sv | 23 ++
 rtl/aes_decrypt_iter.sv | 136 +++++++++++++
 tb/tb_aes_decrypt_iter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decrypt_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryption core.
// Contents: inverse S-box table, FSM state enum, xtime and the x9/x11/x13/x14 multipliers
// used by InvMixColumns. Bytes use [0:7] ordering: bit 0 is the most significant bit.
package aes_decrypt_pkg;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} dec_fsm_t;

  localparam logic [0:7] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1; b[0] is the MSB.
  function automatic logic [0:7] fn_gf_xtime(input logic [0:7] b);
    return {b[1:7], 1'b0} ^ (b[0] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [0:7] fn_gf_mul9(input logic [0:7] b);
    logic [0:7] x2, x4, x8;
    x2 = fn_gf_xtime(b);
    x4 = fn_gf_xtime(x2);
    x8 = fn_gf_xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [0:7] fn_gf_mul11(input logic [0:7] b);
    logic [0:7] x2, x4, x8;
    x2 = fn_gf_xtime(b);
    x4 = fn_gf_xtime(x2);
    x8 = fn_gf_xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [0:7] fn_gf_mul13(input logic [0:7] b);
    logic [0:7] x2, x4, x8;
    x2 = fn_gf_xtime(b);
    x4 = fn_gf_xtime(x2);
    x8 = fn_gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [0:7] fn_gf_mul14(input logic [0:7] b);
    logic [0:7] x2, x4, x8;
    x2 = fn_gf_xtime(b);
    x4 = fn_gf_xtime(x2);
    x8 = fn_gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns on a single 32-bit column (combinational).
// Ports: i_col - column in, byte k = i_col[8k +: 8] is row k; o_col - mixed column, same layout.
module aes_inv_mix_column
  import aes_decrypt_pkg::*;
(
  input  logic [0:31] i_col,
  output logic [0:31] o_col
);

  logic [0:7] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[0:7];
  assign w_a1 = i_col[8:15];
  assign w_a2 = i_col[16:23];
  assign w_a3 = i_col[24:31];

  // Circulant matrix rows {0e 0b 0d 09} rotated right per output row.
  assign o_col[0:7]   = fn_gf_mul14(w_a0) ^ fn_gf_mul11(w_a1) ^ fn_gf_mul13(w_a2) ^ fn_gf_mul9(w_a3);
  assign o_col[8:15]  = fn_gf_mul9(w_a0)  ^ fn_gf_mul14(w_a1) ^ fn_gf_mul11(w_a2) ^ fn_gf_mul13(w_a3);
  assign o_col[16:23] = fn_gf_mul13(w_a0) ^ fn_gf_mul9(w_a1)  ^ fn_gf_mul14(w_a2) ^ fn_gf_mul11(w_a3);
  assign o_col[24:31] = fn_gf_mul11(w_a0) ^ fn_gf_mul13(w_a1) ^ fn_gf_mul9(w_a2)  ^ fn_gf_mul14(w_a3);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; in_ready high only in IDLE
//   in_state            - ciphertext, byte i = [8*i +: 8] (column-major, row = i%4)
//   key_schedule        - expanded key, round key r = [128*r +: 128]
//   out_valid/out_ready - output handshake; o_state held while out_valid
//   o_state             - plaintext, same byte order as in_state
//   busy                - high while a block is in flight (ROUND or DONE)
module aes_decrypt_iter
  import aes_decrypt_pkg::*;
#(
  parameter  int unsigned NUM_ROUNDS = 10,
  localparam int unsigned KS_W       = BLK_W * (NUM_ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:BLK_W-1]  in_state,
  input  logic [0:KS_W-1]   key_schedule,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:BLK_W-1]  o_state,
  output logic              busy
);

  dec_fsm_t             r_fsm, w_fsm_nxt;
  logic [CNT_W-1:0]     r_round_cnt;
  logic [0:BLK_W-1]     r_state, r_o_state;
  logic [0:KS_W-1]      r_ks;
  logic                 r_in_ready, r_out_valid, r_busy;
  logic                 w_load_in, w_step, w_load_out;
  logic [0:BLK_W-1]     w_sub, w_rk, w_added, w_mixed, w_round_out;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid)                w_fsm_nxt = ROUND;
      ROUND:   if (r_round_cnt == '0)       w_fsm_nxt = DONE;
      DONE:    if (out_ready)               w_fsm_nxt = IDLE;
      default:                              w_fsm_nxt = IDLE;
    endcase
  end

  // Output/control decode.
  always_comb begin
    w_load_in  = 1'b0;
    w_step     = 1'b0;
    w_load_out = 1'b0;
    case (r_fsm)
      IDLE:  w_load_in = in_valid;
      ROUND: begin
        w_step     = 1'b1;
        w_load_out = (r_round_cnt == '0);
      end
      default: ;
    endcase
  end

  // Handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_busy      <= (w_fsm_nxt != IDLE);
      r_out_valid <= (w_fsm_nxt == DONE);
    end
  end

  // Datapath registers: initial AddRoundKey with the last round key on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= '0;
      r_ks        <= '0;
      r_round_cnt <= '0;
      r_o_state   <= '0;
    end else begin
      if (w_load_in) begin
        r_state     <= in_state ^ key_schedule[BLK_W*NUM_ROUNDS +: BLK_W];
        r_ks        <= key_schedule;
        r_round_cnt <= CNT_W'(NUM_ROUNDS - 1);
      end else if (w_step) begin
        r_state <= w_round_out;
        if (!w_load_out) r_round_cnt <= r_round_cnt - CNT_W'(1);
      end
      if (w_load_out) r_o_state <= w_round_out;
    end
  end

  // InvShiftRows folded into the InvSubBytes byte gather: new[r][c] = old[r][(c-r) mod 4].
  always_comb begin
    w_sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[8*(4*c+r) +: 8] = INV_SBOX[r_state[8*(4*((c-r+4)%4)+r) +: 8]];
      end
    end
  end

  // Round key mux over the latched schedule.
  always_comb begin
    w_rk = '0;
    for (int unsigned r = 0; r <= NUM_ROUNDS; r++) begin
      if (r_round_cnt == CNT_W'(r)) w_rk = r_ks[BLK_W*r +: BLK_W];
    end
  end

  assign w_added = w_sub ^ w_rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mix_column u_mix (
      .i_col (w_added[32*c +: 32]),
      .o_col (w_mixed[32*c +: 32])
    );
  end

  // Final round (round key 0) skips InvMixColumns.
  assign w_round_out = (r_round_cnt != '0) ? w_mixed : w_added;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign o_state   = r_o_state;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, handshake boundaries,
// mid-block reset and random blocks checked against an AES-128 encryption reference.
module tb_aes_decrypt_iter;

  localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, busy;
  logic [0:127]   in_state = '0;
  logic [0:1407]  key_schedule = '0;
  logic [0:127]   o_state;

  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             acc_cyc[$];
  int             out_cyc[$];
  logic [0:127]   out_data[$];
  logic [7:0]     sbox [256];

  logic [0:1407]  ks_c1, ks_b, ks_z, ks_r;
  logic [0:127]   key_r, pt_r, ct_r;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
    .key_schedule (key_schedule),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .o_state      (o_state),
    .busy         (busy)
  );

  // Record both handshakes with the edge number on which they complete.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) acc_cyc.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      out_data.push_back(o_state);
    end
    cyc++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Forward S-box from the field inverse followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int u = 1; u < 256; u++) if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [0:1407] expand_key(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1407] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] res;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*rnd + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  function automatic logic [0:1407] rand_ks();
    logic [0:1407] k;
    for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_outs(input int n, input string tag);
    int k;
    k = 0;
    while (out_data.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (out_data.size() >= n) else begin
      n_err++;
      $error("FAIL %s: timeout, outputs observed %0d expected %0d", tag, out_data.size(), n);
    end
  endtask

  task automatic clear_q();
    acc_cyc.delete();
    out_cyc.delete();
    out_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_o_state"}, o_state, 128'(0));
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [0:127] ct, input logic [0:1407] ks);
    in_state = ct;
    key_schedule = ks;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [0:127] exp);
    wait_outs(1, {tag, "_wait"});
    if (out_data.size() > 0 && acc_cyc.size() > 0) begin
      check({tag, "_data"}, out_data[0], exp);
      check({tag, "_latency"}, 128'(out_cyc[0] - acc_cyc[0]), 128'(11));
    end
  endtask

  initial begin
    build_sbox();
    ks_c1 = expand_key(128'h000102030405060708090a0b0c0d0e0f);
    ks_b  = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ks_z  = expand_key(128'h0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("por");

    // C.1 with busy-time in_valid and input churn throughout the rounds.
    clear_q();
    out_ready = 1'b1;
    in_state = CT_C1;
    key_schedule = ks_c1;
    in_valid = 1'b1;
    @(negedge clk);
    check("c1_busy", 128'(busy), 128'(1));
    check("c1_in_ready", 128'(in_ready), 128'(0));
    for (int k = 0; k < 8; k++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      key_schedule = rand_ks();
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      key_schedule = rand_ks();
      @(negedge clk);
    end
    check_single("c1", PT_C1);
    check("c1_accepts", 128'(acc_cyc.size()), 128'(1));

    // FIPS-197 appendix B, then idle state right after the output handshake.
    clear_q();
    issue(CT_B, ks_b);
    check_single("fipsb", PT_B);
    check("fipsb_post_valid", 128'(out_valid), 128'(0));
    check("fipsb_post_ready", 128'(in_ready), 128'(1));
    check("fipsb_post_busy", 128'(busy), 128'(0));

    // Zero key with out_ready low: DONE holds, a new block is refused.
    clear_q();
    out_ready = 1'b0;
    issue(CT_Z, ks_z);
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    check("zero_valid", 128'(out_valid), 128'(1));
    if (acc_cyc.size() > 0) check("zero_valid_lat", 128'(cyc - acc_cyc[0]), 128'(11));
    in_state = CT_C1;
    key_schedule = ks_c1;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_in_ready", 128'(in_ready), 128'(0));
      check("hold_o_state", o_state, 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 128'(out_valid), 128'(0));
    check("hold_release_ready", 128'(in_ready), 128'(1));
    check("hold_outputs", 128'(out_data.size()), 128'(1));
    if (out_data.size() > 0) check("hold_data", out_data[0], 128'(0));
    check("hold_accepts", 128'(acc_cyc.size()), 128'(1));

    // Back-to-back C.1 then B with in_valid and out_ready held high.
    clear_q();
    in_state = CT_C1;
    key_schedule = ks_c1;
    in_valid = 1'b1;
    @(negedge clk);
    in_state = CT_B;
    key_schedule = ks_b;
    for (int k = 0; k < 40 && acc_cyc.size() < 2; k++) @(negedge clk);
    in_valid = 1'b0;
    wait_outs(2, "b2b_wait");
    if (out_data.size() >= 2 && acc_cyc.size() >= 2) begin
      check("b2b_first", out_data[0], PT_C1);
      check("b2b_second", out_data[1], PT_B);
      check("b2b_accept_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
      check("b2b_first_lat", 128'(out_cyc[0] - acc_cyc[0]), 128'(11));
      check("b2b_second_lat", 128'(out_cyc[1] - acc_cyc[1]), 128'(11));
    end

    // Reset mid-block (round counter at 5), then a clean B block.
    clear_q();
    issue(CT_C1, ks_c1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_no_output", 128'(out_data.size()), 128'(0));
    check("midrst_idle_valid", 128'(out_valid), 128'(0));
    clear_q();
    issue(CT_B, ks_b);
    check_single("midrst_b", PT_B);

    // Random keys and plaintexts through the encryption reference.
    for (int n = 0; n < 6; n++) begin
      clear_q();
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      ks_r  = expand_key(key_r);
      ct_r  = encrypt(pt_r, ks_r);
      issue(ct_r, ks_r);
      check_single("rand", pt_r);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
